internal_bus_sink: RTL

Destination-side controller for the internal data bus. It accepts a transfer command (source index, destination index), drives the bus's one-hot `CNTL` select for the chosen source, and waits a fixed settle time. It then latches the bus value into one of eight destination registers and reports completion. It sits between the microsequencer and the `internal_data_bus` mux, and is the only block that drives `CNTL`.

---
 rtl/internal_bus_sink.sv | 126 ++++++++++++
 1 files changed

// File: rtl/internal_bus_sink.sv
// Destination-side controller for the internal data bus: drives a one-hot CNTL
// source select, waits SETTLE cycles, then latches BUS_IN into one of eight registers.
module internal_bus_sink #(
  parameter int unsigned SETTLE  = 1,
  parameter logic [7:0]  REG_RST = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic [2:0] src_i,
  input  logic [2:0] dst_i,
  input  logic [7:0] bus_in_i,
  output logic [8:0] cntl_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] reg0_o,
  output logic [7:0] reg1_o,
  output logic [7:0] reg2_o,
  output logic [7:0] reg3_o,
  output logic [7:0] reg4_o,
  output logic [7:0] reg5_o,
  output logic [7:0] reg6_o,
  output logic [7:0] reg7_o
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LATCH
  } state_e;

  // DRIVE lasts SETTLE cycles, so the counter starts one below and exits at zero.
  localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] src_q, src_d;
  logic [2:0] dst_q, dst_d;
  logic [8:0] cntl_q, cntl_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wr_en;
  logic [7:0] regs_q [8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          src_d   = src_i;
          dst_d   = dst_i;
          cnt_d   = SettleLoad;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LATCH: begin
        wr_en   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != IDLE);
    cntl_d = '0;
    if (busy_d) begin
      cntl_d = 9'd1 << src_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      cntl_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cntl_q  <= cntl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= REG_RST;
      end
    end else if (wr_en) begin
      regs_q[dst_q] <= bus_in_i;
    end
  end

  assign cntl_o = cntl_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign reg0_o = regs_q[0];
  assign reg1_o = regs_q[1];
  assign reg2_o = regs_q[2];
  assign reg3_o = regs_q[3];
  assign reg4_o = regs_q[4];
  assign reg5_o = regs_q[5];
  assign reg6_o = regs_q[6];
  assign reg7_o = regs_q[7];

endmodule
